// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS controller and datapath.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DCD   = 3'd1,
        S_EXE   = 3'd2,
        S_MA    = 3'd3,
        S_WB    = 3'd4,
        S_BR    = 3'd5,
        S_JMP   = 3'd6
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [1:0] {NPC_PLUS4, NPC_BRANCH, NPC_JUMP, NPC_JR} npc_op_e;
    typedef enum logic [1:0] {GPR_RT, GPR_RD, GPR_RA} gpr_sel_e;
    typedef enum logic [1:0] {WD_ALU, WD_DM, WD_PC} wd_sel_e;
    typedef enum logic [1:0] {EXT_ZERO, EXT_SIGN, EXT_LUI} ext_op_e;
    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_OR} alu_op_e;

    typedef struct packed {
        logic rtype_alu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic illegal;
    } iclass_t;

endpackage

// File: rtl/mc_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface mc_if;
    import mc_pkg::*;

    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       dm_ready;

    logic       PCWr;
    npc_op_e    NPCOp;
    logic       IRWr;
    logic       RFWr;
    gpr_sel_e   GPRSel;
    wd_sel_e    WDSel;
    ext_op_e    EXTOp;
    logic       BSel;
    alu_op_e    ALUOp;
    logic       dm_req;
    logic       DMWr;
    logic       illegal;
    logic [2:0] state_o;

    modport master (
        input  op, funct, zero, dm_ready,
        output PCWr, NPCOp, IRWr, RFWr, GPRSel, WDSel, EXTOp, BSel, ALUOp,
        output dm_req, DMWr, illegal, state_o
    );

    modport slave (
        output op, funct, zero, dm_ready,
        input  PCWr, NPCOp, IRWr, RFWr, GPRSel, WDSel, EXTOp, BSel, ALUOp,
        input  dm_req, DMWr, illegal, state_o
    );

endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/funct into a one-hot class vector.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output iclass_t    cls_o
);

    always_comb begin
        cls_o = '0;
        case (op_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADDU, FN_SUBU: cls_o.rtype_alu = 1'b1;
                    FN_JR:            cls_o.jr        = 1'b1;
                    default:          cls_o.illegal   = 1'b1;
                endcase
            end
            OP_ORI:  cls_o.ori     = 1'b1;
            OP_LUI:  cls_o.lui     = 1'b1;
            OP_LW:   cls_o.lw      = 1'b1;
            OP_SW:   cls_o.sw      = 1'b1;
            OP_BEQ:  cls_o.beq     = 1'b1;
            OP_J:    cls_o.j       = 1'b1;
            OP_JAL:  cls_o.jal     = 1'b1;
            default: cls_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM: state register, next-state logic and per-cycle
// enables/selects, with a ready handshake on the data-memory access.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    mc_if.master  bus
);

    state_e  state_q, state_d;
    iclass_t cls;
    logic    is_subu;

    mc_decode u_decode (
        .op_i    (bus.op),
        .funct_i (bus.funct),
        .cls_o   (cls)
    );

    assign is_subu     = cls.rtype_alu && (bus.funct == FN_SUBU);
    assign bus.state_o = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DCD;
            S_DCD: begin
                if (cls.rtype_alu || cls.ori || cls.lui || cls.lw || cls.sw) state_d = S_EXE;
                else if (cls.beq)                                          state_d = S_BR;
                else if (cls.j || cls.jal || cls.jr)                       state_d = S_JMP;
                else                                                       state_d = S_FETCH;
            end
            S_EXE:   state_d = (cls.lw || cls.sw) ? S_MA : S_WB;
            S_MA: begin
                if (!bus.dm_ready) state_d = S_MA;
                else if (cls.lw)   state_d = S_WB;
                else               state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs are gated by rst so an access in flight drops without waiting for a clock.
    always_comb begin
        bus.PCWr    = 1'b0;
        bus.IRWr    = 1'b0;
        bus.RFWr    = 1'b0;
        bus.DMWr    = 1'b0;
        bus.dm_req  = 1'b0;
        bus.illegal = 1'b0;
        bus.NPCOp   = NPC_PLUS4;
        bus.GPRSel  = GPR_RT;
        bus.WDSel   = WD_ALU;
        bus.EXTOp   = EXT_ZERO;
        bus.BSel    = 1'b0;
        bus.ALUOp   = ALU_ADD;
        if (!rst) begin
            if (cls.beq || is_subu) bus.ALUOp = ALU_SUB;
            else if (cls.ori)       bus.ALUOp = ALU_OR;
            bus.BSel = cls.ori || cls.lui || cls.lw || cls.sw;
            if (cls.lui)                bus.EXTOp = EXT_LUI;
            else if (cls.lw || cls.sw)  bus.EXTOp = EXT_SIGN;
            if (cls.jal)                   bus.GPRSel = GPR_RA;
            else if (bus.op == OP_RTYPE)   bus.GPRSel = GPR_RD;
            if (cls.jal)     bus.WDSel = WD_PC;
            else if (cls.lw) bus.WDSel = WD_DM;
            // IR still holds the previous instruction during fetch, so NPC stays PC+4 there.
            if (state_q != S_FETCH) begin
                if (cls.beq)              bus.NPCOp = NPC_BRANCH;
                else if (cls.j || cls.jal) bus.NPCOp = NPC_JUMP;
                else if (cls.jr)          bus.NPCOp = NPC_JR;
            end
            case (state_q)
                S_FETCH: begin
                    bus.PCWr = 1'b1;
                    bus.IRWr = 1'b1;
                end
                S_DCD:   bus.illegal = cls.illegal;
                S_MA: begin
                    bus.dm_req = 1'b1;
                    bus.DMWr   = cls.sw;
                end
                S_WB:    bus.RFWr = 1'b1;
                S_BR:    bus.PCWr = bus.zero;
                S_JMP: begin
                    bus.PCWr = 1'b1;
                    bus.RFWr = cls.jal;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus a random instruction mix
// compared against a per-instruction cycle-sequence model.
module tb_mc_ctrl;
    import mc_pkg::*;

    localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5;
    localparam int K_BEQ = 6, K_J = 7, K_JAL = 8, K_JR = 9;
    localparam int K_ILL = 10, K_ILL2 = 11, K_ILL3 = 12;

    // en  = {state[2:0], PCWr, IRWr, RFWr, DMWr, dm_req, illegal}
    // sel = {NPCOp[1:0], ALUOp[1:0], BSel, EXTOp[1:0], GPRSel[1:0], WDSel[1:0]}
    typedef struct {
        logic [8:0]  en;
        logic [10:0] sel;
        logic [10:0] msk;
        int          rdy;
        bit          first;
        int          kind;
        bit          z;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_if bus ();

    mc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    cyc_t        exp_q[$];
    logic [8:0]  obs_en;
    logic [10:0] obs_sel;

    function automatic cyc_t mk(input logic [2:0] st, input logic [5:0] f);
        cyc_t c;
        c.en    = {st, f};
        c.sel   = '0;
        c.msk   = '0;
        c.rdy   = -1;
        c.first = 1'b0;
        c.kind  = 0;
        c.z     = 1'b0;
        return c;
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction, from FETCH up to the next FETCH.
    function automatic void build(input int k, input int w, input bit z);
        cyc_t c;
        c = mk(3'd0, 6'b110000);
        c.first = 1'b1; c.kind = k; c.z = z;
        c.msk[10:9] = 2'b11;
        exp_q.push_back(c);
        if (k >= K_ILL) begin
            exp_q.push_back(mk(3'd1, 6'b000001));
            return;
        end
        exp_q.push_back(mk(3'd1, 6'b000000));
        if (k == K_BEQ) begin
            c = mk(3'd5, {z, 5'b00000});
            c.sel[10:9] = 2'b01; c.sel[8:7] = 2'b01; c.sel[6] = 1'b0;
            c.msk[10:6] = '1;
            exp_q.push_back(c);
        end else if (k == K_J || k == K_JAL || k == K_JR) begin
            c = mk(3'd6, {1'b1, 1'b0, (k == K_JAL), 3'b000});
            c.sel[10:9] = (k == K_JR) ? 2'b11 : 2'b10;
            c.msk[10:9] = '1;
            if (k == K_JAL) begin
                c.sel[3:0] = 4'b1010;
                c.msk[3:0] = '1;
            end
            exp_q.push_back(c);
        end else begin
            c = mk(3'd2, 6'b000000);
            c.sel[8:7] = (k == K_SUBU) ? 2'b01 : (k == K_ORI) ? 2'b10 : 2'b00;
            c.sel[6]   = (k == K_ORI || k == K_LUI || k == K_LW || k == K_SW);
            c.msk[8:6] = '1;
            if (c.sel[6]) begin
                c.sel[5:4] = (k == K_ORI) ? 2'b00 : (k == K_LUI) ? 2'b10 : 2'b01;
                c.msk[5:4] = '1;
            end
            exp_q.push_back(c);
            if (k == K_LW || k == K_SW) begin
                for (int i = 0; i <= w; i++) begin
                    c = mk(3'd3, {3'b000, (k == K_SW), 2'b10});
                    c.rdy = (i == w) ? 1 : 0;
                    exp_q.push_back(c);
                end
            end
            if (k != K_SW) begin
                c = mk(3'd4, 6'b001000);
                c.sel[3:2] = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
                c.sel[1:0] = (k == K_LW) ? 2'b01 : 2'b00;
                c.msk[3:0] = '1;
                exp_q.push_back(c);
            end
        end
    endfunction

    task automatic set_ir(input int k);
        bus.funct = 6'($urandom_range(63));
        case (k)
            K_ADDU: begin bus.op = OP_RTYPE; bus.funct = FN_ADDU; end
            K_SUBU: begin bus.op = OP_RTYPE; bus.funct = FN_SUBU; end
            K_ORI:  bus.op = OP_ORI;
            K_LUI:  bus.op = OP_LUI;
            K_LW:   bus.op = OP_LW;
            K_SW:   bus.op = OP_SW;
            K_BEQ:  bus.op = OP_BEQ;
            K_J:    bus.op = OP_J;
            K_JAL:  bus.op = OP_JAL;
            K_JR:   begin bus.op = OP_RTYPE; bus.funct = FN_JR; end
            K_ILL:  bus.op = 6'h3F;
            K_ILL2: begin bus.op = OP_RTYPE; bus.funct = 6'h20; end
            default: bus.op = 6'h08;
        endcase
    endtask

    // Called just after a rising edge; drives this cycle's inputs and samples at the falling edge.
    task automatic drive_and_sample(input cyc_t e);
        if (e.first) begin
            set_ir(e.kind);
            bus.zero = e.z;
        end
        bus.dm_ready = (e.rdy < 0) ? 1'($urandom_range(1)) : (e.rdy != 0);
        @(negedge clk);
        obs_en  = {bus.state_o, bus.PCWr, bus.IRWr, bus.RFWr, bus.DMWr, bus.dm_req, bus.illegal};
        obs_sel = {bus.NPCOp, bus.ALUOp, bus.BSel, bus.EXTOp, bus.GPRSel, bus.WDSel};
    endtask

    task automatic test_reset();
        set_ir(K_JAL);
        bus.zero     = 1'b1;
        bus.dm_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({bus.state_o, bus.PCWr, bus.IRWr, bus.RFWr, bus.DMWr, bus.dm_req, bus.illegal} !== 9'b0)
            $display("FAIL reset_en got=%b exp=%b", {bus.state_o, bus.PCWr, bus.IRWr, bus.RFWr,
                     bus.DMWr, bus.dm_req, bus.illegal}, 9'b0);
        else n_pass++;
        n_total++;
        if ({bus.NPCOp, bus.ALUOp, bus.BSel, bus.EXTOp, bus.GPRSel, bus.WDSel} !== 11'b0)
            $display("FAIL reset_sel got=%b exp=%b", {bus.NPCOp, bus.ALUOp, bus.BSel, bus.EXTOp,
                     bus.GPRSel, bus.WDSel}, 11'b0);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_addu();
        cyc_t e;
        int   cyc = 0;
        build(K_ADDU, 0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            drive_and_sample(e);
            n_total++;
            if (obs_en !== e.en) $display("FAIL addu_en cyc=%0d got=%b exp=%b", cyc, obs_en, e.en);
            else n_pass++;
            if (e.msk != '0) begin
                n_total++;
                if ((obs_sel & e.msk) !== (e.sel & e.msk))
                    $display("FAIL addu_sel cyc=%0d got=%b exp=%b", cyc, obs_sel & e.msk, e.sel & e.msk);
                else n_pass++;
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_stall();
        cyc_t e;
        int   cyc = 0;
        build(K_LW, 2, 1'b0);
        build(K_ADDU, 0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            drive_and_sample(e);
            n_total++;
            if (obs_en !== e.en) $display("FAIL lw_stall_en cyc=%0d got=%b exp=%b", cyc, obs_en, e.en);
            else n_pass++;
            if (e.msk != '0) begin
                n_total++;
                if ((obs_sel & e.msk) !== (e.sel & e.msk))
                    $display("FAIL lw_stall_sel cyc=%0d got=%b exp=%b", cyc, obs_sel & e.msk, e.sel & e.msk);
                else n_pass++;
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw();
        cyc_t e;
        int   cyc = 0;
        build(K_SW, 0, 1'b0);
        build(K_SW, 1, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            drive_and_sample(e);
            n_total++;
            if (obs_en !== e.en) $display("FAIL sw_en cyc=%0d got=%b exp=%b", cyc, obs_en, e.en);
            else n_pass++;
            if (e.msk != '0) begin
                n_total++;
                if ((obs_sel & e.msk) !== (e.sel & e.msk))
                    $display("FAIL sw_sel cyc=%0d got=%b exp=%b", cyc, obs_sel & e.msk, e.sel & e.msk);
                else n_pass++;
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq();
        cyc_t e;
        int   cyc = 0;
        build(K_BEQ, 0, 1'b1);
        build(K_BEQ, 0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            drive_and_sample(e);
            n_total++;
            if (obs_en !== e.en) $display("FAIL beq_en cyc=%0d got=%b exp=%b", cyc, obs_en, e.en);
            else n_pass++;
            if (e.msk != '0) begin
                n_total++;
                if ((obs_sel & e.msk) !== (e.sel & e.msk))
                    $display("FAIL beq_sel cyc=%0d got=%b exp=%b", cyc, obs_sel & e.msk, e.sel & e.msk);
                else n_pass++;
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jal_jr();
        cyc_t e;
        int   cyc = 0;
        build(K_JAL, 0, 1'b0);
        build(K_JR, 0, 1'b1);
        build(K_J, 0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            drive_and_sample(e);
            n_total++;
            if (obs_en !== e.en) $display("FAIL jal_jr_en cyc=%0d got=%b exp=%b", cyc, obs_en, e.en);
            else n_pass++;
            if (e.msk != '0) begin
                n_total++;
                if ((obs_sel & e.msk) !== (e.sel & e.msk))
                    $display("FAIL jal_jr_sel cyc=%0d got=%b exp=%b", cyc, obs_sel & e.msk, e.sel & e.msk);
                else n_pass++;
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        cyc_t e;
        int   cyc = 0;
        build(K_ILL, 0, 1'b0);
        build(K_ILL2, 0, 1'b0);
        build(K_ORI, 0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            drive_and_sample(e);
            n_total++;
            if (obs_en !== e.en) $display("FAIL illegal_en cyc=%0d got=%b exp=%b", cyc, obs_en, e.en);
            else n_pass++;
            if (e.msk != '0) begin
                n_total++;
                if ((obs_sel & e.msk) !== (e.sel & e.msk))
                    $display("FAIL illegal_sel cyc=%0d got=%b exp=%b", cyc, obs_sel & e.msk, e.sel & e.msk);
                else n_pass++;
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_ma();
        set_ir(K_SW);
        bus.zero     = 1'b0;
        bus.dm_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({bus.state_o, bus.dm_req, bus.DMWr} !== 5'b011_1_1)
            $display("FAIL ma_stall got=%b exp=%b", {bus.state_o, bus.dm_req, bus.DMWr}, 5'b011_1_1);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({bus.state_o, bus.dm_req, bus.DMWr} !== 5'b000_0_0)
            $display("FAIL ma_async_rst got=%b exp=%b", {bus.state_o, bus.dm_req, bus.DMWr}, 5'b000_0_0);
        else n_pass++;
        bus.dm_ready = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({bus.state_o, bus.PCWr, bus.IRWr, bus.dm_req, bus.DMWr} !== 7'b0)
            $display("FAIL ma_rst_hold got=%b exp=%b",
                     {bus.state_o, bus.PCWr, bus.IRWr, bus.dm_req, bus.DMWr}, 7'b0);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_random();
        cyc_t e;
        int   cyc = 0;
        for (int n = 0; n < 60; n++)
            build(int'($urandom_range(K_ILL3)), int'($urandom_range(3)), 1'($urandom_range(1)));
        build(K_ADDU, 0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            drive_and_sample(e);
            n_total++;
            if (obs_en !== e.en) $display("FAIL random_en cyc=%0d got=%b exp=%b", cyc, obs_en, e.en);
            else n_pass++;
            if (e.msk != '0) begin
                n_total++;
                if ((obs_sel & e.msk) !== (e.sel & e.msk))
                    $display("FAIL random_sel cyc=%0d got=%b exp=%b", cyc, obs_sel & e.msk, e.sel & e.msk);
                else n_pass++;
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus.op       = '0;
        bus.funct    = '0;
        bus.zero     = 1'b0;
        bus.dm_ready = 1'b0;
        test_reset();
        test_addu();
        test_lw_stall();
        test_sw();
        test_beq();
        test_jal_jr();
        test_illegal();
        test_reset_mid_ma();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multicycle control FSM for the MIPS core. It sequences the PC register (reset vector 0x0000_3000, word address PC[31:2]), the instruction register, the register file, the ALU and the data-memory port. Opcode and funct come from the registered IR. ALU zero comes from the datapath. It produces per-cycle write enables and mux selects and adds a ready handshake on data memory.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_ORI, 6'b001101, ori
- OP_LW, 6'b100011, lw
- OP_SW, 6'b101011, sw
- OP_BEQ, 6'b000100, beq
- OP_LUI, 6'b001111, lui
- OP_J, 6'b000010, j
- OP_JAL, 6'b000011, jal
- (funct codes: ADDU 6'h21, SUBU 6'h23, JR 6'h08)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU equality result
- dm_ready  in  1  data memory has completed the access this cycle
- PCWr  out  1  PC write enable
- NPCOp  out  2  00 PC+4, 01 branch, 10 j/jal target, 11 jr (rs)
- IRWr  out  1  IR write enable
- RFWr  out  1  register-file write enable
- GPRSel  out  2  destination register: 00 rt, 01 rd, 10 $31
- WDSel  out  2  write data: 00 ALU, 01 DM, 10 PC
- EXTOp  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16
- BSel  out  1  ALU B input: 0 register, 1 extended immediate
- ALUOp  out  2  00 add, 01 sub, 10 or
- dm_req  out  1  data-memory access request
- DMWr  out  1  data-memory write strobe
- illegal  out  1  one-cycle pulse on an unsupported instruction
- state_o  out  3  current state, for debug

Behaviour:
- State encoding: FETCH=0, DCD=1, EXE=2, MA=3, WB=4, BR=5, JMP=6. Codes 7 and above go to FETCH.
- Reset: state goes to FETCH asynchronously. While rst=1, all enables (PCWr, IRWr, RFWr, DMWr, dm_req, illegal) are 0 and all selects are 0. The first FETCH cycle is the first rising edge after rst is released.
- Outputs are combinational from the state and the op/funct inputs. Selects hold their decoded value in every state; enables are asserted only as listed below.
- FETCH: IRWr=1, PCWr=1, NPCOp=00. Next state is DCD.
- DCD:
  - addu, subu, ori, lui, lw, sw go to EXE.
  - beq goes to BR.
  - j, jal, jr (R-type with funct 08) go to JMP.
  - Anything else: illegal=1 for this cycle, then FETCH. The PC has already advanced, so the instruction is skipped.
- EXE:
  - ALUOp: add for addu/lw/sw/lui, sub for subu, or for ori.
  - BSel=1 for ori/lui/lw/sw.
  - EXTOp: 00 for ori, 01 for lw/sw, 10 for lui.
  - lui computes $0 + (imm<<16).
  - lw/sw go to MA; all others go to WB.
- MA: dm_req=1. DMWr=1 for sw, held while in MA.
  - If dm_ready=0, stay in MA with all outputs held.
  - If dm_ready=1: sw goes to FETCH, lw goes to WB.
- WB: RFWr=1, then FETCH.
  - GPRSel: 01 for R-type, 00 otherwise.
  - WDSel: 01 for lw, 00 otherwise.
- BR: ALUOp=sub, BSel=0, NPCOp=01, PCWr=zero. Next state is FETCH. Not-taken leaves PC at PC+4.
- JMP: PCWr=1, then FETCH.
  - NPCOp: 10 for j/jal, 11 for jr.
  - jal additionally asserts RFWr=1, GPRSel=10, WDSel=10, writing PC+4 (the already-advanced PC) to $31.
- CPI: R/I ALU 4, lw 5+w, sw 4+w (w = cycles with dm_ready low), beq 3, j/jal/jr 3, illegal 2.
- Reset mid-operation, including while stalled in MA: the FSM aborts immediately and dm_req/DMWr drop asynchronously. No partial write is retried.
- dm_ready is ignored outside MA.

Decomposition:
- Package mc_pkg:
  - state enum
  - opcode and funct constants
  - NPCOp, GPRSel, WDSel, EXTOp, ALUOp encodings
- The datapath (NPC, mux decode) also uses mc_pkg.
- One sub-module, mc_decode: combinational op/funct into an instruction-class one-hot (rtype_alu, ori, lui, lw, sw, beq, j, jal, jr, illegal).
- mc_ctrl holds the state register, next-state logic and output logic.

Test Plan:
- Reset release, IR=addu $3,$1,$2 (op 00, funct 21) -> states 0,1,2,4,0. FETCH has PCWr=IRWr=1. WB has RFWr=1, GPRSel=01, WDSel=00, ALUOp=00. Exactly 4 cycles.
- lw with dm_ready low 2 cycles, then high -> state 3 held 3 cycles with dm_req=1, DMWr=0. Then WB with WDSel=01, GPRSel=00. Total 7 cycles.
- sw with dm_ready=1 immediately -> MA one cycle with DMWr=1, then FETCH. No RFWr in any cycle.
- beq with zero=1 then zero=0 -> BR has PCWr=1, NPCOp=01 for the first case; PCWr=0 for the second. 3 cycles each.
- jal, then jr (funct 08) -> JMP with PCWr=1. jal: NPCOp=10, RFWr=1, GPRSel=10, WDSel=10. jr: NPCOp=11, RFWr=0.
- Illegal opcode 6'h3F -> illegal pulses for 1 cycle in DCD, then FETCH.
- Reset asserted during the MA stall -> state_o=0 and dm_req=0 within the same cycle, with no clock edge needed.
